arith_issue_unit: RTL
=====================

Name: arith_issue_unit

Overview:
- Sequential successor to the combinational arithmetic decoder, parametrised in register-file size and per-operation latency.
- Accepts arithmetic opcodes over a valid/ready handshake and decodes ALU select, accumulator-mux select, B-operand select and one-hot destination.
- Holds the controls stable for a multi-cycle execute window (MUL/DIV longer than ADD/SUB), then emits a one-cycle writeback strobe.
- Also flags illegal opcodes and divide-by-zero.
- Sits between the instruction decoder front end and the ALU/register file.

Parameters:
- NUM_REGS, 4, register count. Register 0 is the accumulator (A). SRC_W = clog2(NUM_REGS).
- OPCODE_W, 8, opcode width. Must satisfy OPCODE_W - SRC_W - 3 >= 1.
- ARITH_CLASS, 3'b001, class field value (width OPCODE_W-SRC_W-3) identifying arithmetic opcodes.
- ADDSUB_CYCLES, 1, execute cycles for ADD/SUB/ADC/SBB/CMP (>=1).
- MUL_CYCLES, 4, execute cycles for MUL (>=1).
- DIV_CYCLES, 8, execute cycles for DIV (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  opcode valid.
- in_ready  out  1  unit can accept an opcode.
- opcode  in  OPCODE_W  instruction opcode.
- stall  in  1  freezes the execute counter.
- b_is_zero  in  1  selected B operand equals zero; sampled on the first EXEC cycle.
- alu_sel  out  3  ALU operation.
- acc_sel  out  1  accumulator input mux; 0 = ALU result.
- alu_b_sel  out  SRC_W  B operand register index.
- alu_en  out  1  high throughout EXEC.
- wb_en  out  1  one-cycle writeback strobe.
- destination_reg_flag  out  NUM_REGS  one-hot destination; valid while wb_en=1.
- illegal_op  out  1  one-cycle pulse on rejecting an opcode.
- div_fault  out  1  one-cycle pulse on a divide-by-zero abort.

Behaviour:
- Opcode fields: src = opcode[SRC_W-1:0]; op = opcode[SRC_W+2:SRC_W]; class = remaining upper bits.
- op encoding: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 ADC, 101 SBB, 110 CMP, 111 reserved.
- A legal opcode has class == ARITH_CLASS, op != 111, and src < NUM_REGS. (src may be 0, i.e. A op A.)
- Reset state: IDLE, in_ready=1. All other outputs are 0 and the counter is 0.
- States:
  - IDLE:
    - in_ready=1.
    - Accepted on in_valid & in_ready.
    - Legal opcode: latch alu_sel=op, alu_b_sel=src, acc_sel=0; load cnt = LAT-1 (LAT chosen by op); go to EXEC.
    - Illegal opcode: illegal_op=1 on the next cycle; stay IDLE; no EXEC or WB.
  - EXEC:
    - in_ready=0, alu_en=1, latched controls stable.
    - If stall=1, cnt holds.
    - Else if cnt==0, go to WB.
    - Else cnt decrements.
    - DIV with b_is_zero=1 on the first EXEC cycle: go to IDLE next cycle with div_fault pulsed for 1 cycle. No WB; alu_en drops.
  - WB:
    - wb_en=1 for exactly one cycle.
    - destination_reg_flag = 1 at bit 0 (accumulator) for all ops except CMP, which drives all zeros (flags only, wb_en still 1).
    - Then go to IDLE.
- Timing, no stall: opcode accepted at cycle N; EXEC during N+1..N+LAT; WB at N+LAT+1; next accept at N+LAT+2.
- Outside WB, destination_reg_flag=0. Outside EXEC, alu_en=0. alu_sel/alu_b_sel hold their last latched value between ops.
- Stall in IDLE or WB has no effect. Stall asserted on the first DIV EXEC cycle does not delay the b_is_zero check.
- in_valid while in_ready=0: ignored. The upstream stage must hold the opcode.
- Async reset mid-EXEC or mid-WB: immediately IDLE, outputs zero, no wb_en or fault pulse.

Test Plan:
- Reset, then opcode 8'b001_000_01 (ADD B) at cycle N -> alu_sel=000, alu_b_sel=01, alu_en high at N+1; wb_en=1 and destination_reg_flag=4'b0001 at N+2; in_ready=1 at N+3.
- MUL C (8'b001_010_10), stall=1 for 2 cycles mid-EXEC -> alu_en high for 4+2=6 cycles; single wb_en pulse; alu_sel=010, alu_b_sel=10 stable throughout.
- DIV D (8'b001_011_11) with b_is_zero=1 -> div_fault pulses once after 1 EXEC cycle; wb_en never asserts; in_ready returns to 1. Repeat with b_is_zero=0 -> 8 EXEC cycles, then WB.
- Opcodes 8'b010_000_01 (wrong class) and 8'b001_111_00 (reserved op) -> illegal_op pulse each, alu_en stays 0, in_ready stays 1.
- CMP B (8'b001_110_01) -> wb_en=1 with destination_reg_flag=4'b0000; in_valid held high during EXEC is not re-accepted until IDLE.
- rst_n pulled low during DIV EXEC cycle 3 -> all outputs 0 asynchronously; after release, ADD completes normally. With NUM_REGS=8, OPCODE_W=8 and src=3'b101, alu_b_sel=101.

Source files
------------

// File: rtl/arith_issue_unit.sv
// arith_issue_unit: issues arithmetic opcodes to the ALU, holds controls for a per-op execute window, then strobes writeback
module arith_issue_unit #(
  parameter int NUM_REGS = 4,
  parameter int OPCODE_W = 8,
  parameter logic [OPCODE_W-$clog2(NUM_REGS)-4:0] ARITH_CLASS = 'b001,
  parameter int ADDSUB_CYCLES = 1,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8,
  localparam int SRC_W = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                stall,
  input  logic                b_is_zero,
  output logic [2:0]          alu_sel,
  output logic                acc_sel,
  output logic [SRC_W-1:0]    alu_b_sel,
  output logic                alu_en,
  output logic                wb_en,
  output logic [NUM_REGS-1:0] destination_reg_flag,
  output logic                illegal_op,
  output logic                div_fault
);
  localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES)
    ? ((MUL_CYCLES > ADDSUB_CYCLES) ? MUL_CYCLES : ADDSUB_CYCLES)
    : ((DIV_CYCLES > ADDSUB_CYCLES) ? DIV_CYCLES : ADDSUB_CYCLES);
  localparam int CNT_W = $clog2(MAX_LAT + 1);
  localparam logic [2:0] OP_MUL = 3'b010, OP_DIV = 3'b011, OP_CMP = 3'b110, OP_RSV = 3'b111;
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, lat;
  logic [2:0] sel_n, op;
  logic [SRC_W-1:0] b_sel_n, src;
  logic first_exec, first_n, illegal_n, fault_n, legal;
  assign src = opcode[SRC_W-1:0];
  assign op = opcode[SRC_W+2:SRC_W];
  assign legal = opcode[OPCODE_W-1:SRC_W+3] == ARITH_CLASS && op != OP_RSV
                 && {1'b0, src} < (SRC_W+1)'(NUM_REGS);
  assign lat = op == OP_MUL ? CNT_W'(MUL_CYCLES - 1)
             : op == OP_DIV ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(ADDSUB_CYCLES - 1);
  assign in_ready = state == IDLE;
  assign alu_en = state == EXEC;
  assign wb_en = state == WB;
  assign acc_sel = 1'b0;
  // CMP only updates flags, so it writes no register
  assign destination_reg_flag = (wb_en && alu_sel != OP_CMP) ? NUM_REGS'(1) : '0;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sel_n = alu_sel;
    b_sel_n = alu_b_sel;
    first_n = 1'b0;
    illegal_n = 1'b0;
    fault_n = 1'b0;
    if (state == IDLE) begin
      if (in_valid && legal) begin
        state_n = EXEC;
        cnt_n = lat;
        sel_n = op;
        b_sel_n = src;
        first_n = 1'b1;
      end else if (in_valid) begin
        illegal_n = 1'b1;
      end
    end else if (state == EXEC) begin
      // zero divisor is checked on the first cycle even if stalled
      if (first_exec && alu_sel == OP_DIV && b_is_zero) begin
        state_n = IDLE;
        fault_n = 1'b1;
      end else if (!stall) begin
        state_n = cnt == '0 ? WB : EXEC;
        cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
      end
    end else begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      alu_sel <= '0;
      alu_b_sel <= '0;
      first_exec <= 1'b0;
      illegal_op <= 1'b0;
      div_fault <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      alu_sel <= sel_n;
      alu_b_sel <= b_sel_n;
      first_exec <= first_n;
      illegal_op <= illegal_n;
      div_fault <= fault_n;
    end
  end
endmodule
